// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR control path.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fir_state_e;

    localparam int FIR_LENGTH  = 100;
    localparam int FIR_MAC_LAT = 2;

    // Tap address width; never narrower than one bit.
    function automatic int addr_w(input int length);
        return ($clog2(length) < 1) ? 1 : $clog2(length);
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter: counts 0..LENGTH-1 while enabled, wraps, and flags the last tap.
module fir_tap_counter
    import fir_pkg::*;
#(
    parameter int LENGTH = FIR_LENGTH,
    parameter int ADDR_W = addr_w(LENGTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a shared-MAC FIR: accept sample, shift, sweep all taps, drain, hand off result.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int LENGTH  = FIR_LENGTH,
    parameter int MAC_LAT = FIR_MAC_LAT,
    parameter int ADDR_W  = addr_w(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              shift_en,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              tap_last,
    output logic              busy,
    output fir_state_e        state_dbg
);

    // Handshakes: a transfer happens on an edge where valid and ready are both high.
    localparam logic [2:0] DRAIN_LAST = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    fir_state_e state_q, state_d;
    logic [2:0] drain_q, drain_d;
    logic       ready_q, ready_d;
    logic       cnt_last;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE:  if (ready_q && in_valid) state_d = LOAD;
            LOAD:  state_d = MAC;
            MAC: begin
                drain_d = '0;
                if (cnt_last) state_d = (MAC_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered so in_ready stays low through reset and rises on the first edge after.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            drain_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            ready_q <= ready_d;
        end
    end

    fir_tap_counter #(
        .LENGTH (LENGTH),
        .ADDR_W (ADDR_W)
    ) u_tap_counter (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (state_q != MAC),
        .en_i    (state_q == MAC),
        .count_o (tap_addr),
        .last_o  (cnt_last)
    );

    assign in_ready  = ready_q;
    assign shift_en  = (state_q == LOAD);
    assign mac_clr   = (state_q == LOAD);
    assign mac_en    = (state_q == MAC);
    assign tap_last  = (state_q == MAC) && cnt_last;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controls the time-multiplexed FIR datapath: one shared multiplier-accumulator, a tap-indexed coefficient/delay-line memory, and the tap counter.
- Accepts one input sample per valid/ready handshake.
- Pulses the delay-line shift, then steps the tap address through all LENGTH taps while enabling the MAC.
- Waits for the MAC pipeline to drain, then holds the result-valid flag until the downstream stage accepts it.

Parameters:
- LENGTH, 100: number of filter taps; legal range is LENGTH >= 2.
- MAC_LAT, 2: pipeline depth of the multiply-accumulate path in cycles; legal range is 0..7.
- ADDR_W, $clog2(LENGTH): width of the tap address.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  an upstream sample is present.
- in_ready  out  1  the sequencer can accept a sample.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  the accumulator holds a finished result.
- shift_en  out  1  one-cycle pulse: shift the new sample into the delay line.
- mac_clr  out  1  one-cycle pulse: clear the accumulator.
- mac_en  out  1  accumulate the product for the current tap_addr.
- tap_addr  out  ADDR_W  tap index presented to the coefficient and delay memories.
- tap_last  out  1  high when tap_addr == LENGTH-1 and mac_en is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.
- Reset (rst low, asynchronous):
  - state = IDLE, tap counter = 0.
  - All outputs are 0, including in_ready.
  - in_ready rises on the first rising clk edge after rst deasserts.
- States: IDLE, LOAD, MAC, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - If in_valid is high at an edge, the sample is accepted, in_ready falls on that same edge, and the next state is LOAD.
- LOAD: lasts exactly 1 cycle; shift_en = 1, mac_clr = 1, tap_addr = 0. Next state is MAC.
- MAC:
  - Lasts exactly LENGTH cycles; mac_en = 1.
  - tap_addr = 0, 1, …, LENGTH-1, incrementing each cycle.
  - tap_last = 1 on the final cycle.
  - After tap LENGTH-1, the counter wraps to 0 and the state moves to DRAIN, or directly to DONE when MAC_LAT = 0.
- DRAIN:
  - Lasts exactly MAC_LAT cycles.
  - mac_en = 0, tap_addr is held at 0, and a drain counter runs from 0 to MAC_LAT-1.
  - Next state is DONE.
- DONE:
  - out_valid = 1 until out_ready is sampled high.
  - On that edge out_valid falls and the state returns to IDLE, so in_ready = 1 in the following cycle.
  - out_ready is ignored in every other state.
- Latency: the accept edge is cycle 0. out_valid first reads high in cycle 2+LENGTH+MAC_LAT; for the defaults that is cycle 104.
- Minimum handshake-to-handshake period: 3+LENGTH+MAC_LAT cycles, assuming out_ready is held high.
- in_valid is ignored whenever in_ready is 0. No sample is ever accepted while busy, and none is queued.
- Reset asserted mid-operation: everything aborts immediately to the reset values. No partial out_valid and no further shift_en pulse may occur.
- The tap counter never exceeds LENGTH-1, and tap_addr is 0 in every state except MAC.
- shift_en and mac_clr are exactly one cycle wide per accepted sample.

Decomposition:
- Shared package (fir_pkg):
  - State encoding enum: IDLE=0, LOAD=1, MAC=2, DRAIN=3, DONE=4.
  - Defaults FIR_LENGTH = 100 and FIR_MAC_LAT = 2.
  - ADDR_W derivation helper.
- One sub-module, fir_tap_counter:
  - Enable-gated count 0..LENGTH-1 with a synchronous clear.
  - Last-tap flag decoded at LENGTH-1.
  - Asynchronous active-low reset.
- The sequencer instantiates it for tap_addr. The drain counter is kept inline in the sequencer.

Test Plan:
1. Reset release with in_valid=0 → all outputs 0 during reset; in_ready=1 from the first edge after release; busy=0; tap_addr=0.
2. Single sample, LENGTH=100, MAC_LAT=2, out_ready=1 → cycle 1: shift_en=mac_clr=1. Cycles 2–101: mac_en=1, tap_addr 0→99, tap_last only at cycle 101. Cycles 102–103: drain. out_valid=1 in cycle 104 for exactly 1 cycle. in_ready=1 in cycle 105.
3. Back-pressure: out_ready=0 for 10 cycles after out_valid rises → out_valid held 10 cycles; in_ready=0 throughout; in_valid pulses during that time are ignored.
4. Reset pulsed at tap_addr=37 → outputs are 0 asynchronously. After release, a new sample gives a clean sequence starting at tap_addr=0 with no stray out_valid.
5. LENGTH=4, MAC_LAT=0, continuous in_valid=1 and out_ready=1 → one accept every 7 cycles; tap_addr sequence 0,1,2,3; out_valid in cycle 6 after each accept.
6. Random in_valid/out_ready over 1000 samples → the count of shift_en pulses equals the count of accepted samples equals the count of out_valid handshakes. mac_en count = 100 × samples. tap_addr is never ≥ LENGTH.
